mux_arb_fifo: RTL and testbench

MUX_ARB_FIFO -- requirements
Module: mux_arb_fifo

---
 rtl/mux_arb_fifo.sv | 106 ++++++++++
 tb/tb_mux_arb_fifo.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/mux_arb_fifo.sv
// Two-lane round-robin arbiter feeding a 4-entry, 2-bit FIFO with a sticky underflow flag.
// Optional macro PARITY_EN adds an even-parity bit per entry and the parity_out port.
module mux_arb_fifo (
    input  logic       clk,
    input  logic       reset_L,
    input  logic [1:0] data_in0,
    input  logic       valid_in0,
    output logic       ready_in0,
    input  logic [1:0] data_in1,
    input  logic       valid_in1,
    output logic       ready_in1,
    input  logic       pop,
    output logic [1:0] data_out,
    output logic       valid_out,
    output logic       fifo_full,
`ifdef PARITY_EN
    output logic       err_underflow,
    output logic       parity_out
`else
    output logic       err_underflow
`endif
);

`ifdef PARITY_EN
    localparam int W = 3;
`else
    localparam int W = 2;
`endif

    logic [W-1:0] mem_q [4];
    logic [1:0]   wr_ptr_q, wr_ptr_d;
    logic [1:0]   rd_ptr_q, rd_ptr_d;
    logic [2:0]   count_q, count_d;
    logic         rr_q, rr_d;
    logic         err_q, err_d;

    logic         do_pop, can_accept, grant0, grant1, push;
    logic [1:0]   sel_data;
    logic [W-1:0] wdata;
    logic [W-1:0] head;

    assign valid_out = (count_q != 3'd0);
    assign fifo_full = (count_q == 3'd4);
    assign do_pop    = pop && valid_out;
    assign can_accept = !fifo_full || do_pop;

    // rr names the lane that wins when both request
    assign grant0 = can_accept && valid_in0 && (!valid_in1 || !rr_q);
    assign grant1 = can_accept && valid_in1 && (!valid_in0 ||  rr_q);
    assign push   = grant0 || grant1;

    // Gated so no handshake is presented while reset holds the FIFO empty
    assign ready_in0 = grant0 && reset_L;
    assign ready_in1 = grant1 && reset_L;

    assign sel_data = grant0 ? data_in0 : data_in1;
`ifdef PARITY_EN
    assign wdata = {^sel_data, sel_data};
`else
    assign wdata = sel_data;
`endif

    assign head     = mem_q[rd_ptr_q];
    assign data_out = valid_out ? head[1:0] : 2'b00;
`ifdef PARITY_EN
    assign parity_out = valid_out ? head[2] : 1'b0;
`endif
    assign err_underflow = err_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        rr_d     = rr_q;
        err_d    = err_q;
        if (push)   wr_ptr_d = wr_ptr_q + 2'd1;
        if (do_pop) rd_ptr_d = rd_ptr_q + 2'd1;
        case ({push, do_pop})
            2'b10:   count_d = count_q + 3'd1;
            2'b01:   count_d = count_q - 3'd1;
            default: count_d = count_q;
        endcase
        if (grant0) rr_d = 1'b1;
        else if (grant1) rr_d = 1'b0;
        if (pop && !valid_out) err_d = 1'b1;
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            wr_ptr_q <= 2'd0;
            rd_ptr_q <= 2'd0;
            count_q  <= 3'd0;
            rr_q     <= 1'b0;
            err_q    <= 1'b0;
            for (int i = 0; i < 4; i++) mem_q[i] <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            rr_q     <= rr_d;
            err_q    <= err_d;
            if (push) mem_q[wr_ptr_q] <= wdata;
        end
    end

endmodule

// File: tb/tb_mux_arb_fifo.sv
// Randomized and directed bench for mux_arb_fifo with a queue-based scoreboard.
module tb_mux_arb_fifo;

    logic       clk, reset_L;
    logic [1:0] data_in0, data_in1, data_out;
    logic       valid_in0, valid_in1, ready_in0, ready_in1;
    logic       pop, valid_out, fifo_full, err_underflow;
`ifdef PARITY_EN
    logic       parity_out;
`endif

    mux_arb_fifo dut (
        .clk(clk), .reset_L(reset_L),
        .data_in0(data_in0), .valid_in0(valid_in0), .ready_in0(ready_in0),
        .data_in1(data_in1), .valid_in1(valid_in1), .ready_in1(ready_in1),
        .pop(pop), .data_out(data_out), .valid_out(valid_out),
        .fifo_full(fifo_full),
`ifdef PARITY_EN
        .err_underflow(err_underflow), .parity_out(parity_out)
`else
        .err_underflow(err_underflow)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int errors  = 0;

    // Reference model: contents as a queue, plus occupancy, priority lane, sticky error
    logic [1:0] exp_q [$];
    int         mcount = 0;
    logic       mrr    = 1'b0;
    logic       merr   = 1'b0;

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: whatever sits at the head must be the oldest word the model expects
    always @(negedge clk) begin
        if (reset_L) begin
            if (valid_out) begin
                if (exp_q.size() == 0) chk("head_unexpected", {2'b0, data_out}, 4'hf);
                else begin
                    chk("data_out", {2'b0, data_out}, {2'b0, exp_q[0]});
`ifdef PARITY_EN
                    chk("parity_out", {3'b0, parity_out}, {3'b0, ^exp_q[0]});
`endif
                    if (pop) void'(exp_q.pop_front());
                end
            end else begin
                chk("data_out_empty", {2'b0, data_out}, 4'h0);
`ifdef PARITY_EN
                chk("parity_out_empty", {3'b0, parity_out}, 4'h0);
`endif
            end
        end
    end

    // One cycle: drive, check combinational handshake, then advance the model at the edge
    task automatic step(input logic v0, input logic [1:0] d0,
                        input logic v1, input logic [1:0] d1, input logic p);
        logic can, g0, g1, mv;
        #1;
        valid_in0 = v0; data_in0 = d0;
        valid_in1 = v1; data_in1 = d1;
        pop = p;
        #1;
        mv  = (mcount != 0);
        can = (mcount != 4) || (p && mv);
        g0 = 1'b0; g1 = 1'b0;
        if (can && v0 && v1) begin
            if (mrr) g1 = 1'b1; else g0 = 1'b1;
        end else if (can && v0) g0 = 1'b1;
        else if (can && v1) g1 = 1'b1;
        chk("ready_in0", {3'b0, ready_in0}, {3'b0, g0});
        chk("ready_in1", {3'b0, ready_in1}, {3'b0, g1});
        chk("valid_out", {3'b0, valid_out}, {3'b0, mv});
        chk("fifo_full", {3'b0, fifo_full}, {3'b0, mcount == 4});
        chk("err_underflow", {3'b0, err_underflow}, {3'b0, merr});
        @(posedge clk);
        if (p && !mv) merr = 1'b1;
        if (g0) begin exp_q.push_back(d0); mrr = 1'b1; end
        if (g1) begin exp_q.push_back(d1); mrr = 1'b0; end
        mcount = mcount + ((g0 || g1) ? 1 : 0) - ((p && mv) ? 1 : 0);
    endtask

    task automatic check_all_zero();
        chk("rst_data_out",  {2'b0, data_out},  4'h0);
        chk("rst_valid_out", {3'b0, valid_out}, 4'h0);
        chk("rst_fifo_full", {3'b0, fifo_full}, 4'h0);
        chk("rst_ready_in0", {3'b0, ready_in0}, 4'h0);
        chk("rst_ready_in1", {3'b0, ready_in1}, 4'h0);
        chk("rst_err",       {3'b0, err_underflow}, 4'h0);
`ifdef PARITY_EN
        chk("rst_parity",    {3'b0, parity_out}, 4'h0);
`endif
    endtask

    // Asynchronous reset mid-cycle with both lanes requesting
    task automatic do_reset();
        #1;
        valid_in0 = 1'b1; valid_in1 = 1'b1; pop = 1'b0;
        #2;
        reset_L = 1'b0;
        #1;
        check_all_zero();
        exp_q.delete();
        mcount = 0; mrr = 1'b0; merr = 1'b0;
        @(posedge clk);
        #2;
        valid_in0 = 1'b0; valid_in1 = 1'b0;
        reset_L = 1'b1;
        @(posedge clk);
    endtask

    task automatic drain();
        for (int i = 0; i < 8 && mcount > 0; i++) step(0, 2'd0, 0, 2'd0, 1);
    endtask

    initial begin
        reset_L = 1'b0;
        valid_in0 = 1'b0; valid_in1 = 1'b0; pop = 1'b0;
        data_in0 = 2'd0; data_in1 = 2'd0;
        #2;
        check_all_zero();
        @(posedge clk);
        #2 reset_L = 1'b1;
        @(posedge clk);

        // Alternation to full, then full with and without pop
        for (int i = 0; i < 4; i++) step(1, 2'b01, 1, 2'b10, 0);
        step(1, 2'b01, 1, 2'b10, 0);
        step(1, 2'b11, 1, 2'b10, 1);
        step(1, 2'b00, 1, 2'b11, 1);
        drain();

        // Pointer wrap with a counting sequence
        for (int i = 0; i < 10; i++) step(1, 2'(i % 4), 0, 2'd0, (i > 0));
        drain();

        // Mid-stream reset with three entries held
        for (int i = 0; i < 3; i++) step(1, 2'(i + 1), 0, 2'd0, 0);
        do_reset();
        step(0, 2'd0, 0, 2'd0, 0);
        step(0, 2'd3, 1, 2'd2, 0);
        drain();

        // Underflow is sticky until reset
        step(0, 2'd0, 0, 2'd0, 1);
        for (int i = 0; i < 5; i++) step(0, 2'd0, 0, 2'd0, 0);
        do_reset();
        step(0, 2'd0, 0, 2'd0, 0);

        // Parity of 2'b11 then 2'b10 as each reaches the head
        step(1, 2'b11, 0, 2'd0, 0);
        step(1, 2'b10, 0, 2'd0, 0);
        drain();

        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 1), 2'($urandom_range(0, 3)),
                 $urandom_range(0, 1), 2'($urandom_range(0, 3)),
                 ($urandom_range(0, 9) < 4));
        drain();
        step(0, 2'd0, 0, 2'd0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
